// File: rtl/alu4.sv
// alu4 -- 4-bit registered ALU with zero, carry/borrow and signed-overflow flags.
//
// Every rising edge of clk samples A, B and op and loads the result and flags, so
// results appear exactly one cycle after their operands. A new operation is
// accepted every cycle. rst is synchronous and active-high; it overrides the
// operation sampled at the same edge.
//
// Ports:
//   clk       in   1  system clock, rising-edge active
//   rst       in   1  synchronous active-high reset
//   A         in   4  operand A (unsigned or two's complement)
//   B         in   4  operand B (unused by NOT, INC, DEC)
//   op        in   3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 INC, 111 DEC
//   Y         out  4  registered result
//   zero      out  1  registered, set when Y == 0000
//   carry     out  1  registered carry-out (ADD/INC) or borrow (SUB/DEC)
//   overflow  out  1  registered two's-complement overflow
module alu4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [2:0] op,
    output logic [3:0] Y,
    output logic       zero,
    output logic       carry,
    output logic       overflow
);

    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpAnd = 3'b010,
        OpOr  = 3'b011,
        OpXor = 3'b100,
        OpNot = 3'b101,
        OpInc = 3'b110,
        OpDec = 3'b111
    } op_e;

    logic [3:0] y_d;
    logic       carry_d;
    logic       overflow_d;
    logic [3:0] y_q;
    logic       zero_q;
    logic       carry_q;
    logic       overflow_q;

    // 5-bit arithmetic: bit 4 is carry-out for additions and borrow for
    // subtractions (the zero-extended difference goes negative when A < B).
    logic [4:0] add_res;
    logic [4:0] sub_res;
    logic [4:0] inc_res;
    logic [4:0] dec_res;

    always_comb begin
        add_res = {1'b0, A} + {1'b0, B};
        sub_res = {1'b0, A} - {1'b0, B};
        inc_res = {1'b0, A} + 5'd1;
        dec_res = {1'b0, A} - 5'd1;
    end

    always_comb begin
        y_d        = 4'b0000;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        unique case (op_e'(op))
            OpAdd: begin
                y_d        = add_res[3:0];
                carry_d    = add_res[4];
                overflow_d = (A[3] == B[3]) && (add_res[3] != A[3]);
            end
            OpSub: begin
                y_d        = sub_res[3:0];
                carry_d    = sub_res[4];
                overflow_d = (A[3] != B[3]) && (sub_res[3] != A[3]);
            end
            OpAnd: y_d = A & B;
            OpOr:  y_d = A | B;
            OpXor: y_d = A ^ B;
            OpNot: y_d = ~A;
            OpInc: begin
                y_d        = inc_res[3:0];
                carry_d    = inc_res[4];
                overflow_d = (A == 4'b0111);
            end
            OpDec: begin
                y_d        = dec_res[3:0];
                carry_d    = dec_res[4];
                overflow_d = (A == 4'b1000);
            end
            default: begin
                y_d        = 4'b0000;
                carry_d    = 1'b0;
                overflow_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q        <= 4'b0000;
            zero_q     <= 1'b1;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            y_q        <= y_d;
            // Flag derived from this cycle's result, not the registered Y.
            zero_q     <= (y_d == 4'b0000);
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        Y        = y_q;
        zero     = zero_q;
        carry    = carry_q;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_alu4.sv
// Directed-vector bench for alu4: reset, each op family, boundaries,
// back-to-back latency with a mid-stream reset, and a full A/B/op sweep.
module tb_alu4;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] op;
    logic [3:0] Y;
    logic       zero;
    logic       carry;
    logic       overflow;

    int vectors;
    int miscompares;

    alu4 dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .op       (op),
        .Y        (Y),
        .zero     (zero),
        .carry    (carry),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector word: {A[3:0], B[3:0], op[2:0], Y[3:0], zero, carry, overflow}
    localparam int NBasic = 8;
    localparam logic [17:0] BASIC [NBasic] = '{
        {4'd3, 4'd1, 3'b000, 4'd4,  1'b0, 1'b0, 1'b0},  // ADD 3+1
        {4'd3, 4'd1, 3'b001, 4'd2,  1'b0, 1'b0, 1'b0},  // SUB 3-1
        {4'd3, 4'd1, 3'b010, 4'd1,  1'b0, 1'b0, 1'b0},  // AND
        {4'd3, 4'd1, 3'b011, 4'd3,  1'b0, 1'b0, 1'b0},  // OR
        {4'd3, 4'd1, 3'b100, 4'd2,  1'b0, 1'b0, 1'b0},  // XOR
        {4'd3, 4'd1, 3'b101, 4'd12, 1'b0, 1'b0, 1'b0},  // NOT
        {4'd5, 4'd9, 3'b010, 4'd1,  1'b0, 1'b0, 1'b0},  // AND 0101&1001
        {4'd12, 4'd3, 3'b010, 4'd0, 1'b1, 1'b0, 1'b0}   // AND -> zero
    };

    localparam int NBound = 10;
    localparam logic [17:0] BOUND [NBound] = '{
        {4'd15, 4'd0, 3'b110, 4'd0,  1'b1, 1'b1, 1'b0},  // INC 15 wraps
        {4'd0,  4'd0, 3'b111, 4'd15, 1'b0, 1'b1, 1'b0},  // DEC 0 borrows
        {4'd7,  4'd7, 3'b000, 4'd14, 1'b0, 1'b0, 1'b1},  // ADD 7+7 overflow
        {4'd3,  4'd3, 3'b001, 4'd0,  1'b1, 1'b0, 1'b0},  // SUB 3-3 zero
        {4'd7,  4'd5, 3'b110, 4'd8,  1'b0, 1'b0, 1'b1},  // INC 7 overflow
        {4'd8,  4'd5, 3'b111, 4'd7,  1'b0, 1'b0, 1'b1},  // DEC 8 overflow
        {4'd0,  4'd1, 3'b001, 4'd15, 1'b0, 1'b1, 1'b0},  // SUB 0-1 borrow
        {4'd8,  4'd1, 3'b001, 4'd7,  1'b0, 1'b0, 1'b1},  // SUB -8-1 overflow
        {4'd8,  4'd8, 3'b000, 4'd0,  1'b1, 1'b1, 1'b1},  // ADD -8+-8
        {4'd15, 4'd1, 3'b000, 4'd0,  1'b1, 1'b1, 1'b0}   // ADD 15+1 carry only
    };

    // Back-to-back word: {rst, A, B, op, Y, zero, carry, overflow}
    localparam int NB2b = 7;
    localparam logic [18:0] B2B [NB2b] = '{
        {1'b0, 4'd2,  4'd5, 3'b000, 4'd7,  1'b0, 1'b0, 1'b0},
        {1'b0, 4'd9,  4'd6, 3'b100, 4'd15, 1'b0, 1'b0, 1'b0},
        {1'b0, 4'd4,  4'd6, 3'b001, 4'd14, 1'b0, 1'b1, 1'b0},
        {1'b1, 4'd7,  4'd7, 3'b000, 4'd0,  1'b1, 1'b0, 1'b0},  // reset discards ADD
        {1'b0, 4'd10, 4'd0, 3'b101, 4'd5,  1'b0, 1'b0, 1'b0},
        {1'b0, 4'd15, 4'd0, 3'b110, 4'd0,  1'b1, 1'b1, 1'b0},
        {1'b0, 4'd6,  4'd3, 3'b011, 4'd7,  1'b0, 1'b0, 1'b0}
    };

    task automatic test_reset();
        logic [6:0] got;
        rst = 1'b1; A = 4'd7; B = 4'd7; op = 3'b000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        got = {Y, zero, carry, overflow};
        vectors++;
        if (got !== 7'b0000_1_0_0) begin
            miscompares++;
            $display("FAIL reset: got %b required %b", got, 7'b0000_1_0_0);
        end
        // First valid result on the first edge with rst low.
        rst = 1'b0; A = 4'd3; B = 4'd1; op = 3'b000;
        @(posedge clk); #1;
        got = {Y, zero, carry, overflow};
        vectors++;
        if (got !== 7'b0100_0_0_0) begin
            miscompares++;
            $display("FAIL first_after_reset: got %b required %b", got, 7'b0100_0_0_0);
        end
    endtask

    task automatic test_basic();
        logic [17:0] w;
        logic [6:0]  got;
        for (int i = 0; i < NBasic; i++) begin
            w = BASIC[i];
            A = w[17:14]; B = w[13:10]; op = w[9:7];
            @(posedge clk); #1;
            got = {Y, zero, carry, overflow};
            vectors++;
            if (got !== w[6:0]) begin
                miscompares++;
                $display("FAIL basic[%0d] A=%0d B=%0d op=%b: got %b required %b",
                         i, w[17:14], w[13:10], w[9:7], got, w[6:0]);
            end
        end
    endtask

    task automatic test_boundary();
        logic [17:0] w;
        logic [6:0]  got;
        for (int i = 0; i < NBound; i++) begin
            w = BOUND[i];
            A = w[17:14]; B = w[13:10]; op = w[9:7];
            @(posedge clk); #1;
            got = {Y, zero, carry, overflow};
            vectors++;
            if (got !== w[6:0]) begin
                miscompares++;
                $display("FAIL boundary[%0d] A=%0d B=%0d op=%b: got %b required %b",
                         i, w[17:14], w[13:10], w[9:7], got, w[6:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [18:0] w;
        logic [6:0]  prev;
        logic [6:0]  got;
        prev = 7'b0;
        for (int i = 0; i < NB2b; i++) begin
            w = B2B[i];
            rst = w[18]; A = w[17:14]; B = w[13:10]; op = w[9:7];
            // New inputs must not show until the next edge.
            if (i > 0) begin
                #2;
                got = {Y, zero, carry, overflow};
                vectors++;
                if (got !== prev) begin
                    miscompares++;
                    $display("FAIL b2b_hold[%0d]: got %b required %b", i, got, prev);
                end
            end
            @(posedge clk); #1;
            got = {Y, zero, carry, overflow};
            vectors++;
            if (got !== w[6:0]) begin
                miscompares++;
                $display("FAIL b2b[%0d] rst=%b: got %b required %b", i, w[18], got, w[6:0]);
            end
            prev = w[6:0];
        end
        rst = 1'b0;
    endtask

    task automatic test_sweep();
        int         sa, sb, r, sr;
        logic [6:0] exp;
        logic [6:0] got;
        int         bad;
        bad = 0;
        for (int o = 0; o < 8; o++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    A = 4'(a); B = 4'(b); op = 3'(o);
                    sa = (a >= 8) ? a - 16 : a;
                    sb = (b >= 8) ? b - 16 : b;
                    exp = 7'b0;
                    case (o)
                        0: begin
                            r = a + b; sr = sa + sb;
                            exp[6:3] = 4'(r % 16);
                            exp[1] = (r >= 16);
                            exp[0] = (sr > 7) || (sr < -8);
                        end
                        1: begin
                            r = a - b; sr = sa - sb;
                            exp[6:3] = 4'((r + 16) % 16);
                            exp[1] = (a < b);
                            exp[0] = (sr > 7) || (sr < -8);
                        end
                        2: exp[6:3] = 4'(a) & 4'(b);
                        3: exp[6:3] = 4'(a) | 4'(b);
                        4: exp[6:3] = 4'(a) ^ 4'(b);
                        5: exp[6:3] = 4'(15 - a);
                        6: begin
                            exp[6:3] = 4'((a + 1) % 16);
                            exp[1] = (a == 15);
                            exp[0] = (sa + 1 > 7);
                        end
                        default: begin
                            exp[6:3] = 4'((a + 15) % 16);
                            exp[1] = (a == 0);
                            exp[0] = (sa - 1 < -8);
                        end
                    endcase
                    exp[2] = (exp[6:3] == 4'd0);
                    @(posedge clk); #1;
                    got = {Y, zero, carry, overflow};
                    vectors++;
                    if (got !== exp) begin
                        miscompares++;
                        bad++;
                        if (bad <= 10)
                            $display("FAIL sweep A=%0d B=%0d op=%0d: got %b required %b",
                                     a, b, o, got, exp);
                    end
                end
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; A = 4'd0; B = 4'd0; op = 3'b000;
        test_reset();
        test_basic();
        test_boundary();
        test_back_to_back();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
